// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and widths for the FreezeTime latency responder
package ft_pkg;

    typedef enum logic [1:0] {
        FT_IDLE = 2'd0,
        FT_WAIT = 2'd1,
        FT_ACK  = 2'd2
    } ft_state_t;

    localparam int FT_WAIT_W  = 8;
    localparam int FT_STALL_W = 32;

endpackage

// File: rtl/ft_bytemask_ram.sv
// rtl/ft_bytemask_ram.sv - single-port RAM with byte write enables and a registered read
module ft_bytemask_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [ADDR_W-1:0]     adr,
    input  logic [DATA_W-1:0]     dat_w,
    output logic [DATA_W-1:0]     dat_r
);

    localparam int SEL_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (en && we) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (sel[i]) begin
                    mem[adr][8*i +: 8] <= dat_w[8*i +: 8];
                end
            end
        end
    end

    // Read register only loads on a read access so the last read word stays visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dat_r <= '0;
        end else if (en && !we) begin
            dat_r <= mem[adr];
        end
    end

endmodule

// File: rtl/ft_wb_latency_responder.sv
// rtl/ft_wb_latency_responder.sv - Wishbone classic RAM responder with programmable wait states
module ft_wb_latency_responder
    import ft_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    wb_bus_cyc,
    input  logic                    wb_bus_stb,
    input  logic                    wb_bus_we,
    input  logic [ADDR_W-1:0]       wb_bus_adr,
    input  logic [DATA_W-1:0]       wb_bus_dat_w,
    input  logic [DATA_W/8-1:0]     wb_bus_sel,
    output logic [DATA_W-1:0]       wb_bus_dat_r,
    output logic                    wb_bus_ack,
    input  logic [FT_WAIT_W-1:0]    cfg_rd_wait,
    input  logic [FT_WAIT_W-1:0]    cfg_wr_wait,
    input  logic                    freeze,
    input  logic                    stall_clr,
    output logic [FT_STALL_W-1:0]   stall_cycles,
    output logic                    busy
);

    ft_state_t               state_q, state_d;
    logic [FT_WAIT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]       adr_q;
    logic                    we_q;
    logic [DATA_W-1:0]       dat_q;
    logic [DATA_W/8-1:0]     sel_q;
    logic                    ack_q;
    logic [FT_STALL_W-1:0]   stall_q;
    logic                    req;
    logic                    is_idle;
    logic                    ram_en;
    logic [FT_WAIT_W-1:0]    req_wait;

    assign req      = wb_bus_cyc && wb_bus_stb;
    assign is_idle  = (state_q == FT_IDLE);
    assign req_wait = wb_bus_we ? cfg_wr_wait : cfg_rd_wait;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ram_en  = 1'b0;
        case (state_q)
            FT_IDLE: begin
                if (req) begin
                    if (req_wait == '0) begin
                        state_d = FT_ACK;
                        ram_en  = 1'b1;
                    end else begin
                        state_d = FT_WAIT;
                        cnt_d   = req_wait;
                    end
                end
            end
            FT_WAIT: begin
                if (!wb_bus_cyc) begin
                    state_d = FT_IDLE;
                    cnt_d   = '0;
                end else if (!freeze) begin
                    cnt_d = cnt_q - FT_WAIT_W'(1);
                    if (cnt_q == FT_WAIT_W'(1)) begin
                        state_d = FT_ACK;
                        ram_en  = 1'b1;
                    end
                end
            end
            FT_ACK:  state_d = FT_IDLE;
            default: state_d = FT_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FT_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == FT_ACK);
            if (is_idle && req) begin
                adr_q <= wb_bus_adr;
                we_q  <= wb_bus_we;
                dat_q <= wb_bus_dat_w;
                sel_q <= wb_bus_sel;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (stall_clr) begin
            stall_q <= '0;
        end else if (req && !ack_q && (stall_q != '1)) begin
            stall_q <= stall_q + FT_STALL_W'(1);
        end
    end

    // A zero-wait request reaches the RAM in its IDLE cycle, before the latches are valid.
    ft_bytemask_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (ram_en),
        .we      (is_idle ? wb_bus_we    : we_q),
        .sel     (is_idle ? wb_bus_sel   : sel_q),
        .adr     (is_idle ? wb_bus_adr   : adr_q),
        .dat_w   (is_idle ? wb_bus_dat_w : dat_q),
        .dat_r   (wb_bus_dat_r)
    );

    assign wb_bus_ack   = ack_q;
    assign stall_cycles = stall_q;
    assign busy         = !is_idle;

endmodule

// File: tb/tb_ft_wb_latency_responder.sv
// tb/tb_ft_wb_latency_responder.sv - self-checking bench for the Wishbone latency responder
module tb_ft_wb_latency_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_bus_cyc = 1'b0;
    logic        wb_bus_stb = 1'b0;
    logic        wb_bus_we = 1'b0;
    logic [9:0]  wb_bus_adr = '0;
    logic [31:0] wb_bus_dat_w = '0;
    logic [3:0]  wb_bus_sel = '0;
    logic [31:0] wb_bus_dat_r;
    logic        wb_bus_ack;
    logic [7:0]  cfg_rd_wait = '0;
    logic [7:0]  cfg_wr_wait = '0;
    logic        freeze = 1'b0;
    logic        stall_clr = 1'b0;
    logic [31:0] stall_cycles;
    logic        busy;

    always #5 clock = ~clock;

    ft_wb_latency_responder #(.ADDR_W(10), .DATA_W(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .wb_bus_cyc   (wb_bus_cyc),
        .wb_bus_stb   (wb_bus_stb),
        .wb_bus_we    (wb_bus_we),
        .wb_bus_adr   (wb_bus_adr),
        .wb_bus_dat_w (wb_bus_dat_w),
        .wb_bus_sel   (wb_bus_sel),
        .wb_bus_dat_r (wb_bus_dat_r),
        .wb_bus_ack   (wb_bus_ack),
        .cfg_rd_wait  (cfg_rd_wait),
        .cfg_wr_wait  (cfg_wr_wait),
        .freeze       (freeze),
        .stall_clr    (stall_clr),
        .stall_cycles (stall_cycles),
        .busy         (busy)
    );

    typedef struct {
        logic        we;
        logic [9:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          w;
        logic [15:0] fmask;
        int          abort_at;
        int          cfg_chg;
        int          exp_ack;
        logic [31:0] exp_data;
        logic [31:0] exp_stall;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem_m [0:1023];
    logic [31:0] exp_stall = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Model: after cycle 0 a request owes W non-frozen WAIT cycles; ack arrives the cycle after the last one.
    task automatic run_txn(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int w, input logic [15:0] fmask,
                           input int abort_at, input int cfg_chg, input bit rnd,
                           output int act_ack, output logic [31:0] rdata,
                           output logic [31:0] stall_delta);
        int          rem;
        int          k;
        bit          done;
        bit          aborted;
        logic [31:0] st0;
        step();
        chk("idle_ack", 32'(wb_bus_ack), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        st0     = stall_cycles;
        act_ack = 0;
        rdata   = '0;
        done    = 0;
        aborted = 0;
        wb_bus_cyc   = 1'b1;
        wb_bus_stb   = 1'b1;
        wb_bus_we    = we;
        wb_bus_adr   = adr;
        wb_bus_dat_w = dat;
        wb_bus_sel   = sel;
        if (we) begin
            cfg_wr_wait = 8'(w);
            cfg_rd_wait = 8'($urandom_range(0, 255));
        end else begin
            cfg_rd_wait = 8'(w);
            cfg_wr_wait = 8'($urandom_range(0, 255));
        end
        freeze = rnd ? ($urandom_range(0, 3) == 0) : fmask[0];
        rem = w;
        k   = 0;
        while (!done && k < 400) begin
            if (wb_bus_cyc && wb_bus_stb && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (k >= 1) begin
                if (!wb_bus_cyc) aborted = 1;
                else if (!freeze) rem--;
            end
            step();
            k++;
            if (aborted) begin
                chk("abort_ack", 32'(wb_bus_ack), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                freeze = 1'b0;
                done = 1;
            end else if (rem == 0) begin
                chk("ack", 32'(wb_bus_ack), 32'd1);
                chk("ack_busy", 32'(busy), 32'd1);
                if (wb_bus_ack) act_ack = k;
                rdata = wb_bus_dat_r;
                if (we) mem_m[adr] = merge(mem_m[adr], dat, sel);
                else chk("rdata", wb_bus_dat_r, mem_m[adr]);
                chk("stall", stall_cycles, exp_stall);
                wb_bus_cyc = 1'b0;
                wb_bus_stb = 1'b0;
                freeze     = 1'b0;
                done       = 1;
            end else begin
                chk("wait_ack", 32'(wb_bus_ack), 32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
                freeze = rnd ? ($urandom_range(0, 3) == 0) : ((k < 16) ? fmask[k] : 1'b0);
                if (cfg_chg >= 0 && k == 1) begin
                    cfg_rd_wait = 8'(cfg_chg);
                    cfg_wr_wait = 8'(cfg_chg);
                end
                if (rnd) begin
                    cfg_rd_wait = 8'($urandom_range(0, 255));
                    cfg_wr_wait = 8'($urandom_range(0, 255));
                end
                if (k == abort_at) begin
                    wb_bus_cyc = 1'b0;
                    wb_bus_stb = 1'b0;
                end
            end
        end
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
        stall_delta = stall_cycles - st0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl [12];
        int          act_ack;
        logic [31:0] rdata;
        logic [31:0] sdelta;

        //              we    adr    dat           sel   w    fmask   ab cfg ack data          stall
        tbl[0]  = '{1'b1, 10'd5,    32'hDEADBEEF, 4'hF, 0,   16'h0,  0, -1, 1,  32'h0,        32'd1};
        tbl[1]  = '{1'b0, 10'd5,    32'h0,        4'h0, 3,   16'h0,  0, -1, 4,  32'hDEADBEEF, 32'd4};
        tbl[2]  = '{1'b1, 10'd7,    32'hAABBCCDD, 4'hF, 1,   16'h0,  0, -1, 2,  32'h0,        32'd2};
        tbl[3]  = '{1'b1, 10'd7,    32'h11223344, 4'h5, 0,   16'h0,  0, -1, 1,  32'h0,        32'd1};
        tbl[4]  = '{1'b0, 10'd7,    32'h0,        4'h0, 0,   16'h0,  0, -1, 1,  32'hAA22CC44, 32'd1};
        tbl[5]  = '{1'b0, 10'd7,    32'h0,        4'h0, 2,   16'hE,  0, -1, 6,  32'hAA22CC44, 32'd6};
        tbl[6]  = '{1'b1, 10'd7,    32'h0,        4'hF, 4,   16'h0,  2, -1, 0,  32'h0,        32'd2};
        tbl[7]  = '{1'b0, 10'd7,    32'h0,        4'h0, 1,   16'h0,  0, -1, 2,  32'hAA22CC44, 32'd2};
        tbl[8]  = '{1'b0, 10'd5,    32'h0,        4'h0, 5,   16'h0,  0, 1,  6,  32'hDEADBEEF, 32'd6};
        tbl[9]  = '{1'b0, 10'd5,    32'h0,        4'h0, 0,   16'h1,  0, -1, 1,  32'hDEADBEEF, 32'd1};
        tbl[10] = '{1'b1, 10'd1023, 32'h12345678, 4'hF, 255, 16'h0,  0, -1, 256, 32'h0,       32'd256};
        tbl[11] = '{1'b0, 10'd1023, 32'h0,        4'h0, 0,   16'h0,  0, -1, 1,  32'h12345678, 32'd1};

        step();
        step();
        chk("rst_ack", 32'(wb_bus_ack), 32'd0);
        chk("rst_dat_r", wb_bus_dat_r, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_txn(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].w, tbl[i].fmask,
                    tbl[i].abort_at, tbl[i].cfg_chg, 1'b0, act_ack, rdata, sdelta);
            chk($sformatf("tbl%0d_ack_cycle", i), 32'(act_ack), 32'(tbl[i].exp_ack));
            chk($sformatf("tbl%0d_stall_delta", i), sdelta, tbl[i].exp_stall);
            if (!tbl[i].we) chk($sformatf("tbl%0d_data", i), rdata, tbl[i].exp_data);
        end

        // Reset in the middle of a write's WAIT phase.
        step();
        wb_bus_cyc = 1'b1; wb_bus_stb = 1'b1; wb_bus_we = 1'b1;
        wb_bus_adr = 10'd5; wb_bus_dat_w = 32'h0; wb_bus_sel = 4'hF; cfg_wr_wait = 8'd6;
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(wb_bus_ack), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_stall", stall_cycles, 32'd0);
        chk("midrst_dat_r", wb_bus_dat_r, 32'd0);
        wb_bus_cyc = 1'b0; wb_bus_stb = 1'b0;
        step();
        chk("midrst_ack_hold", 32'(wb_bus_ack), 32'd0);
        reset_n = 1'b1;
        exp_stall = '0;
        run_txn(1'b0, 10'd5, 32'h0, 4'h0, 1, 16'h0, 0, -1, 1'b0, act_ack, rdata, sdelta);
        chk("midrst_ram_kept", rdata, 32'hDEADBEEF);

        // Saturation of the stall counter from a preloaded value.
        step();
        force dut.stall_q = 32'hFFFF_FFFC;
        #1;
        release dut.stall_q;
        exp_stall = 32'hFFFF_FFFC;
        run_txn(1'b0, 10'd5, 32'h0, 4'h0, 4, 16'h0, 0, -1, 1'b0, act_ack, rdata, sdelta);
        chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);

        // stall_clr wins over a stall in the same cycle.
        step();
        wb_bus_cyc = 1'b1; wb_bus_stb = 1'b1; wb_bus_we = 1'b0;
        wb_bus_adr = 10'd5; cfg_rd_wait = 8'd2; freeze = 1'b0; stall_clr = 1'b1;
        step();
        chk("clr_prio", stall_cycles, 32'd0);
        stall_clr = 1'b0;
        step();
        step();
        chk("clr_ack", 32'(wb_bus_ack), 32'd1);
        chk("clr_stall", stall_cycles, 32'd2);
        chk("clr_data", wb_bus_dat_r, 32'hDEADBEEF);
        wb_bus_cyc = 1'b0; wb_bus_stb = 1'b0;
        exp_stall = 32'd2;

        for (int a = 0; a < 16; a++) begin
            run_txn(1'b1, 10'(a), $urandom, 4'hF, $urandom_range(0, 3), 16'h0, 0, -1, 1'b0,
                    act_ack, rdata, sdelta);
        end
        for (int n = 0; n < 120; n++) begin
            run_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 4), 16'h0,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                    -1, 1'b1, act_ack, rdata, sdelta);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ft_wb_latency_responder.md
# ft_wb_latency_responder

Wishbone classic (B3, non-pipelined) responder: a word-addressed internal RAM that answers each read/write after a programmable number of wait states. It is the FreezeTime memory-latency emulator: it sits at the target end of an instruction or data bus whose initiator side is watched by the bus stall detector. A `freeze` input can hold any transaction in its wait phase indefinitely. A saturating counter reports stall cycles using the same definition as the detector.

## Interface
- `ADDR_W`, 10: word-address width; RAM depth is 2**ADDR_W words.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `clock`  in  1  single module clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wb_bus_cyc`  in  1  bus cycle valid.
- `wb_bus_stb`  in  1  strobe.
- `wb_bus_we`  in  1  1 = write, 0 = read.
- `wb_bus_adr`  in  ADDR_W  word address.
- `wb_bus_dat_w`  in  DATA_W  write data.
- `wb_bus_sel`  in  DATA_W/8  byte enables for writes.
- `wb_bus_dat_r`  out  DATA_W  read data; registered.
- `wb_bus_ack`  out  1  acknowledge; registered, one cycle wide.
- `cfg_rd_wait`  in  8  wait states for reads (W).
- `cfg_wr_wait`  in  8  wait states for writes (W).
- `freeze`  in  1  hold the wait-state countdown.
- `stall_clr`  in  1  synchronous clear of `stall_cycles`.
- `stall_cycles`  out  32  saturating stall-cycle count.
- `busy`  out  1  high when the FSM is not IDLE.

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE, with `cyc & stb` sampled high:
  - Latch address, we, write data and sel.
  - Pick W from `cfg_rd_wait` or `cfg_wr_wait` according to `we`; the cfg value is captured here and later changes do not affect this transaction.
  - W = 0: go to ACK. Otherwise load counter with W and go to WAIT.
- WAIT:
  - `cyc` low: abort. Go to IDLE with no ack and no RAM write.
  - `freeze` high: counter and state hold.
  - Counter = 1: go to ACK.
  - Otherwise: decrement the counter.
- On the edge that enters ACK:
  - Write: RAM bytes where `sel[i]` = 1 are updated; other bytes are unchanged.
  - Read: `wb_bus_dat_r` loads the full RAM word.
- ACK: `wb_bus_ack` = 1 for exactly this cycle, then always go to IDLE. `freeze` and `cyc` are ignored in ACK.
- `wb_bus_dat_r` holds its value outside read acks. It is not cleared after the ack.
- `stall_cycles` increments on every cycle with `cyc & stb & ~wb_bus_ack`:
  - Saturates at 0xFFFF_FFFF.
  - `stall_clr` sets it to 0 and takes priority over an increment in the same cycle.
- Address is taken modulo the RAM depth; no error response, ERR/RTY are not implemented.

## Timing
- Call the cycle in which the request is first sampled in IDLE cycle 0. With `freeze` low, `wb_bus_ack` is high in cycle W+1.
- Each freeze cycle spent in WAIT adds one cycle to the latency.
- Back-to-back: the IDLE cycle after ACK can accept the next request, giving one transfer per W+2 cycles.
- A write is visible to a read accepted in the cycle after its ack.
- Reset values: `wb_bus_ack` 0, `wb_bus_dat_r` 0, `busy` 0, `stall_cycles` 0, state IDLE, counter 0. RAM contents are not reset.
- `reset_n` asserted mid-transaction: ack drops immediately and asynchronously, any pending write is discarded, and the FSM restarts in IDLE.
- `freeze` high in IDLE does not block acceptance of a request.

## Structure
- Package `ft_pkg`:
  - State enum `ft_state_t` {FT_IDLE, FT_WAIT, FT_ACK}.
  - Constants `FT_WAIT_W = 8` and `FT_STALL_W = 32`.
- Sub-module `ft_bytemask_ram`: single-port synchronous RAM with byte-write enables and a registered read, inferable as block RAM. The FSM, counter and stall counter stay in the top level.

## Test plan
- Read, W=3, RAM[5]=0xDEADBEEF, request in cycle 0 → ack high only in cycle 4, `dat_r` = 0xDEADBEEF, `stall_cycles` = 4.
- Write, W=0, adr 7, dat 0x11223344, sel 0b0101, RAM[7] preset 0xAABBCCDD → ack in cycle 1; a following read returns 0xAA22CC44.
- Read, W=2, `freeze` high in cycles 1–3 → ack in cycle 6; `busy` high in cycles 1–6.
- Write, W=4, `cyc` dropped in cycle 2 → no ack, RAM unchanged, FSM in IDLE by cycle 3; the next request is accepted normally.
- `cfg_rd_wait` changed from 5 to 1 in cycle 1 of a read → ack still in cycle 6. Then `reset_n` pulsed low mid-WAIT of a write → ack stays 0, RAM unchanged, `stall_cycles` = 0.
- Preload `stall_cycles` near saturation via long freezes → holds at 0xFFFF_FFFF; `stall_clr` in the same cycle as a stall → 0.
